fetch_sequencer: RTL and testbench

//   Front end of the multi-cycle CPU: owns the program counter, drives the instruction-memory

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front end of the multi-cycle CPU.
// Owns the program counter, presents the instruction-memory address, latches
// the fetched word and steps through the IF/ID/EX/WB phases. A halt opcode
// parks the sequencer in HALT after its own write-back until reset.
module fetch_sequencer #(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = 6'h3f
) (
  input  logic               clk,
  input  logic               rstd,
  input  logic               run,
  input  logic [31:0]        imem_rdata,
  input  logic [31:0]        nextpc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic [3:0]         phase,
  output logic               mem_en,
  output logic               wb_en,
  output logic               halted,
  output logic [31:0]        retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_retired;
  logic [3:0]  w_phase;
  logic        w_memEn;
  logic        w_wbEn;
  logic        w_halted;
  logic        w_isHalt;

  // The latched instruction decides, during WB, whether we stop or continue.
  assign w_isHalt = (r_ins[31:26] == HALT_OP);

  // Phase register; reset drops straight back to IF from any phase.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next phase plus every state-decoded output; run only matters in IF.
  always_comb begin
    w_nextState = r_state;
    w_phase     = 4'b0000;
    w_memEn     = 1'b0;
    w_wbEn      = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_IF: begin
        w_phase = 4'b0001;
        if (run) begin
          w_nextState = S_ID;
        end
      end
      S_ID: begin
        w_phase     = 4'b0010;
        w_nextState = S_EX;
      end
      S_EX: begin
        w_phase     = 4'b0100;
        w_memEn     = 1'b1;
        w_nextState = S_WB;
      end
      S_WB: begin
        w_phase     = 4'b1000;
        w_wbEn      = 1'b1;
        w_nextState = w_isHalt ? S_HALT : S_IF;
      end
      S_HALT: begin
        w_halted    = 1'b1;
        w_nextState = S_HALT;
      end
      default: begin
        w_nextState = S_IF;
      end
    endcase
  end

  // Datapath: ins is written only on the ID edge (memory data is valid one
  // cycle after the IF address); pc and the retire count move only on WB.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_pc      <= RESET_PC;
      r_ins     <= 32'd0;
      r_retired <= 32'd0;
    end else begin
      case (r_state)
        S_ID: begin
          r_ins <= imem_rdata;
        end
        S_WB: begin
          r_retired <= r_retired + 32'd1;
          if (!w_isHalt) begin
            r_pc <= nextpc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Addresses beyond the memory size alias through truncation of pc.
  assign imem_addr = r_pc[IMEM_AW-1:0];
  assign ins       = r_ins;
  assign pc        = r_pc;
  assign retired   = r_retired;
  assign phase     = w_phase;
  assign mem_en    = w_memEn;
  assign wb_en     = w_wbEn;
  assign halted    = w_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized bench for fetch_sequencer with an
// instruction-level reference model (pc, retire count, halt flag).
module tb_fetch_sequencer;

  logic        clk;
  logic        rstd;
  logic        run;
  logic [31:0] imem_rdata;
  logic [31:0] nextpc;
  logic [7:0]  imem_addr;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [3:0]  phase;
  logic        mem_en;
  logic        wb_en;
  logic        halted;
  logic [31:0] retired;

  logic [31:0] imem [0:255];

  int          testsRun;
  int          testsFailed;

  logic [31:0] mPc;
  logic [31:0] mRetired;
  logic        mHalted;

  fetch_sequencer #(
    .IMEM_AW (8),
    .RESET_PC(32'd0),
    .HALT_OP (6'h3f)
  ) dut (
    .clk       (clk),
    .rstd      (rstd),
    .run       (run),
    .imem_rdata(imem_rdata),
    .nextpc    (nextpc),
    .imem_addr (imem_addr),
    .ins       (ins),
    .pc        (pc),
    .phase     (phase),
    .mem_en    (mem_en),
    .wb_en     (wb_en),
    .halted    (halted),
    .retired   (retired)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
  end

  // Absolute time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nonHaltWord();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) begin
      w[31] = 1'b0;
    end
    return w;
  endfunction

  task automatic applyReset();
    rstd   = 1'b0;
    run    = 1'b0;
    nextpc = $urandom;
    tick();
    tick();
    rstd     = 1'b1;
    mPc      = 32'd0;
    mRetired = 32'd0;
    mHalted  = 1'b0;
  endtask

  // Runs one instruction from IF: stall cycles with run=0, then the four
  // phases, comparing against the instruction-level model.
  task automatic test_instruction(input logic [31:0] npc, input int stall);
    logic [31:0] expIns;
    expIns = imem[mPc[7:0]];
    run = 1'b0;
    for (int i = 0; i < stall; i++) begin
      nextpc = $urandom;
      tick();
      testsRun++;
      if (phase !== 4'b0001 || pc !== mPc || retired !== mRetired) begin
        testsFailed++;
        $display("[TB] FAIL stall: phase=%b pc=%h retired=%0d, expected phase=0001 pc=%h retired=%0d",
                 phase, pc, retired, mPc, mRetired);
      end
    end
    testsRun++;
    if (phase !== 4'b0001 || imem_addr !== mPc[7:0] || mem_en !== 1'b0 || wb_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL if_phase: phase=%b imem_addr=%h mem_en=%b wb_en=%b, expected 0001 %h 0 0",
               phase, imem_addr, mem_en, wb_en, mPc[7:0]);
    end
    run = 1'b1;
    tick();
    testsRun++;
    if (phase !== 4'b0010 || mem_en !== 1'b0 || wb_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL id_phase: phase=%b mem_en=%b wb_en=%b, expected 0010 0 0", phase, mem_en, wb_en);
    end
    run    = 1'($urandom_range(0, 1));
    nextpc = $urandom;
    tick();
    testsRun++;
    if (phase !== 4'b0100 || mem_en !== 1'b1 || wb_en !== 1'b0 || ins !== expIns) begin
      testsFailed++;
      $display("[TB] FAIL ex_phase: phase=%b mem_en=%b wb_en=%b ins=%h, expected 0100 1 0 %h",
               phase, mem_en, wb_en, ins, expIns);
    end
    run    = 1'($urandom_range(0, 1));
    nextpc = $urandom;
    tick();
    nextpc = npc;
    testsRun++;
    if (phase !== 4'b1000 || mem_en !== 1'b0 || wb_en !== 1'b1 || ins !== expIns || pc !== mPc) begin
      testsFailed++;
      $display("[TB] FAIL wb_phase: phase=%b mem_en=%b wb_en=%b ins=%h pc=%h, expected 1000 0 1 %h %h",
               phase, mem_en, wb_en, ins, pc, expIns, mPc);
    end
    tick();
    run      = 1'b0;
    mRetired = mRetired + 32'd1;
    if (expIns[31:26] == 6'h3f) begin
      mHalted = 1'b1;
    end else begin
      mPc = npc;
    end
    testsRun++;
    if (phase !== (mHalted ? 4'b0000 : 4'b0001) || pc !== mPc || retired !== mRetired ||
        halted !== mHalted || ins !== expIns) begin
      testsFailed++;
      $display("[TB] FAIL retire: phase=%b pc=%h retired=%0d halted=%b ins=%h, expected phase=%b pc=%h retired=%0d halted=%b ins=%h",
               phase, pc, retired, halted, ins, (mHalted ? 4'b0000 : 4'b0001), mPc, mRetired, mHalted, expIns);
    end
  endtask

  task automatic test_reset();
    applyReset();
    testsRun++;
    if (phase !== 4'b0001 || pc !== 32'd0 || ins !== 32'd0 || retired !== 32'd0 ||
        halted !== 1'b0 || imem_addr !== 8'h00 || mem_en !== 1'b0 || wb_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: phase=%b pc=%h ins=%h retired=%0d halted=%b imem_addr=%h, expected 0001 0 0 0 0 00",
               phase, pc, ins, retired, halted, imem_addr);
    end
  endtask

  task automatic test_basic();
    imem[0] = 32'h04210005;
    test_instruction(32'd1, 0);
    testsRun++;
    if (pc !== 32'd1 || retired !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL basic_addi: pc=%h retired=%0d, expected pc=1 retired=1", pc, retired);
    end
  endtask

  task automatic test_stall();
    test_instruction(mPc + 32'd1, 5);
  endtask

  task automatic test_branch();
    test_instruction(32'h00000010, 0);
    testsRun++;
    if (pc !== 32'h00000010 || imem_addr !== 8'h10) begin
      testsFailed++;
      $display("[TB] FAIL branch: pc=%h imem_addr=%h, expected pc=00000010 imem_addr=10", pc, imem_addr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      test_instruction($urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_wrap();
    test_instruction(32'h000001FF, 1);
    testsRun++;
    if (imem_addr !== 8'hFF) begin
      testsFailed++;
      $display("[TB] FAIL wrap_ff: imem_addr=%h, expected ff", imem_addr);
    end
    test_instruction(32'h00000200, 0);
    testsRun++;
    if (imem_addr !== 8'h00 || pc !== 32'h00000200) begin
      testsFailed++;
      $display("[TB] FAIL wrap_00: imem_addr=%h pc=%h, expected 00 00000200", imem_addr, pc);
    end
  endtask

  task automatic test_halt();
    applyReset();
    imem[0] = nonHaltWord();
    imem[2] = 32'hFC000000;
    test_instruction(32'd2, 0);
    test_instruction($urandom, 0);
    for (int i = 0; i < 6; i++) begin
      run    = 1'($urandom_range(0, 1));
      nextpc = $urandom;
      tick();
      testsRun++;
      if (phase !== 4'b0000 || halted !== 1'b1 || pc !== 32'd2 || retired !== 32'd2 ||
          mem_en !== 1'b0 || wb_en !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL halt_hold: phase=%b halted=%b pc=%h retired=%0d mem_en=%b wb_en=%b, expected 0000 1 2 2 0 0",
                 phase, halted, pc, retired, mem_en, wb_en);
      end
    end
    imem[2] = nonHaltWord();
  endtask

  task automatic test_reset_mid_wb();
    applyReset();
    test_instruction(32'd1, 0);
    run = 1'b1;
    tick();
    tick();
    tick();
    nextpc = 32'h00000020;
    testsRun++;
    if (phase !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_wb: phase=%b, expected 1000", phase);
    end
    #2;
    rstd = 1'b0;
    #1;
    testsRun++;
    if (pc !== 32'd0 || retired !== 32'd0 || phase !== 4'b0001 || ins !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: pc=%h retired=%0d phase=%b ins=%h, expected 0 0 0001 0",
               pc, retired, phase, ins);
    end
    tick();
    rstd     = 1'b1;
    mPc      = 32'd0;
    mRetired = 32'd0;
    mHalted  = 1'b0;
    testsRun++;
    if (pc !== 32'd0 || retired !== 32'd0 || phase !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL reset_held_edge: pc=%h retired=%0d phase=%b, expected 0 0 0001", pc, retired, phase);
    end
    test_instruction(32'd5, 0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstd        = 1'b0;
    run         = 1'b0;
    nextpc      = 32'd0;
    for (int a = 0; a < 256; a++) begin
      imem[a] = nonHaltWord();
    end
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_random();
    test_wrap();
    test_halt();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
